isqrt_pipe_arbiter: RTL and testbench

Shares one pipelined isqrt instance among N_REQ independent requesters. It issues at most one square-root request per cycle, chosen round-robin, and tags each issue with the requester index. It routes every isqrt result back to the requester that issued it. It sits between several formula FSMs and the single isqrt instance in a top-level wrapper, so several formula engines can keep the isqrt pipeline full.

---
 rtl/isqrt_arb_pkg.sv | 34 +++
 rtl/isqrt_arb_tag_fifo.sv | 49 ++++
 rtl/isqrt_pipe_arbiter.sv | 104 ++++++++++
 tb/tb_isqrt_pipe_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_arb_pkg.sv
// Shared constants and the round-robin search helper for the isqrt request arbiter.
package isqrt_arb_pkg;

  localparam int ISQRT_ARB_N_REQ_DEF     = 4;
  localparam int ISQRT_ARB_TAG_DEPTH_DEF = 16;
  localparam int ISQRT_ARB_MAX_REQ       = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_grant_t;

  // First set bit of vld scanning ptr, ptr+1, ... modulo n; n is at most ISQRT_ARB_MAX_REQ.
  function automatic rr_grant_t rr_pick(input logic [ISQRT_ARB_MAX_REQ-1:0] vld,
                                        input int n, input int ptr);
    rr_grant_t r;
    int        idx;
    logic [2:0] idx3;
    r = '0;
    for (int k = ISQRT_ARB_MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        idx3 = 3'(idx);
        if (vld[idx3]) begin
          r.found = 1'b1;
          r.idx   = idx3;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each in-flight isqrt operation.
module isqrt_arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count != (PTR_W + 1)'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count guards every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/isqrt_pipe_arbiter.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters with tagged result routing.
// Optional macro ISQRT_ARB_ORPHAN_CHECK_EN enables the sticky err_orphan flag.
module isqrt_pipe_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = ISQRT_ARB_N_REQ_DEF,
  parameter int TAG_DEPTH = ISQRT_ARB_TAG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [N_REQ*32-1:0] req_x,
  output logic [N_REQ-1:0]    req_rdy,
  output logic [N_REQ-1:0]    rsp_vld,
  output logic [15:0]         rsp_y,
  output logic                isqrt_x_vld,
  output logic [31:0]         isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [15:0]         isqrt_y,
  output logic                busy,
  output logic                err_orphan
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] g;
  logic [TAG_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  rr_grant_t        pick;
  logic             full;
  logic             issue;
  logic             pop;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pick        = rr_pick(8'(req_vld), N_REQ, int'(ptr));
    g           = TAG_W'(pick.idx);
    full        = (count == CNT_W'(TAG_DEPTH));
    issue       = pick.found && !full && !rst;
    pop         = isqrt_y_vld && (count != '0);
    req_rdy     = '0;
    isqrt_x     = '0;
    isqrt_x_vld = issue;
    if (issue) begin
      req_rdy[g] = 1'b1;
      isqrt_x    = req_x[32*g +: 32];
    end
    case ({issue, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  isqrt_arb_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (g),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      rsp_vld <= '0;
      rsp_y   <= '0;
      busy    <= 1'b0;
    end else begin
      if (issue) ptr <= (g == TAG_W'(N_REQ - 1)) ? '0 : g + 1'b1;
      rsp_vld <= pop ? (N_REQ'(1) << head) : '0;
      if (pop) rsp_y <= isqrt_y;
      busy <= (count_next != '0);
    end
  end

`ifdef ISQRT_ARB_ORPHAN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (isqrt_y_vld && (count == '0)) begin
      err_orphan <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && isqrt_y_vld && (count == '0)) $error("isqrt_pipe_arbiter: orphan isqrt result");
  end
`endif
`else
  // Results arriving with no tag outstanding are dropped without a trace.
  assign err_orphan = 1'b0;
`endif

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Self-checking bench: directed tables and sequences plus random traffic against a queue-based model.
module tb_isqrt_pipe_arbiter;
  import isqrt_arb_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 16;
`ifdef ISQRT_ARB_ORPHAN_CHECK_EN
  localparam bit ORPHAN_EN = 1'b1;
`else
  localparam bit ORPHAN_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*32-1:0] req_x;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    rsp_vld;
  logic [15:0]     rsp_y;
  logic            isqrt_x_vld;
  logic [31:0]     isqrt_x;
  logic            isqrt_y_vld;
  logic [15:0]     isqrt_y;
  logic            busy;
  logic            err_orphan;

  always #5 clk = ~clk;

  isqrt_pipe_arbiter #(.N_REQ(N), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .busy(busy), .err_orphan(err_orphan)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > longint'(x)) r--;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 16'(r);
  endfunction

  // Behavioural isqrt pipeline with selectable latency; flushes on the shared reset.
  int         lat = 3;
  logic       force_orphan = 1'b0;
  logic       pv [32];
  logic [15:0] pd [32];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= isqrt_x_vld;
      pd[0] <= ref_isqrt(isqrt_x);
      for (int i = 1; i < 32; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_comb begin
    isqrt_y_vld = force_orphan | pv[lat-1];
    isqrt_y     = pd[lat-1];
  end

  // Reference model: outstanding requests in issue order, round-robin pointer, sticky orphan flag.
  typedef struct { int tag; logic [31:0] x; } pend_t;
  pend_t        q[$];
  pend_t        p;
  int           m_ptr;
  bit           m_err;
  bit           model_ok = 1'b0;
  bit           chk_rsp_y;
  logic [N-1:0] exp_rsp_vld;
  logic [15:0]  exp_rsp_y;
  logic [N-1:0] exp_rdy;
  logic [31:0]  exp_x;
  int           mg;
  bit           mfound;

  always begin
    @(posedge clk);
    #4;
    if (rst) begin
      check("rst_req_rdy", 32'(req_rdy), 0);
      check("rst_isqrt_x_vld", 32'(isqrt_x_vld), 0);
      check("rst_isqrt_x", isqrt_x, 0);
      q.delete();
      m_ptr = 0; m_err = 0; exp_rsp_vld = '0; exp_rsp_y = '0; chk_rsp_y = 1; model_ok = 1;
    end else if (model_ok) begin
      check("m_rsp_vld", 32'(rsp_vld), 32'(exp_rsp_vld));
      if (chk_rsp_y) check("m_rsp_y", 32'(rsp_y), 32'(exp_rsp_y));
      check("m_busy", 32'(busy), 32'(q.size() != 0));
      check("m_err_orphan", 32'(err_orphan), 32'(m_err));
      mfound = 0; mg = 0;
      for (int k = 0; k < N; k++) begin
        if (!mfound && req_vld[(m_ptr + k) % N]) begin
          mfound = 1;
          mg = (m_ptr + k) % N;
        end
      end
      exp_rdy = '0; exp_x = '0;
      if (mfound && q.size() < DEPTH) begin
        exp_rdy[mg] = 1'b1;
        exp_x = req_x[32*mg +: 32];
      end
      check("m_req_rdy", 32'(req_rdy), 32'(exp_rdy));
      check("m_isqrt_x_vld", 32'(isqrt_x_vld), 32'(exp_rdy != 0));
      check("m_isqrt_x", isqrt_x, exp_x);
      exp_rsp_vld = '0; chk_rsp_y = 0;
      if (isqrt_y_vld) begin
        if (q.size() > 0) begin
          p = q.pop_front();
          exp_rsp_vld[p.tag] = 1'b1;
          exp_rsp_y = ref_isqrt(p.x);
          chk_rsp_y = 1;
        end else if (ORPHAN_EN) begin
          m_err = 1;
        end
      end
      if (exp_rdy != 0) begin
        q.push_back('{tag: mg, x: exp_x});
        m_ptr = (mg + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic wait_idle();
    req_vld = '0;
    for (int k = 0; k < 300 && busy; k++) tick();
    tick();
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic set_lat(input int n);
    repeat (34) tick();
    lat = n;
  endtask

  typedef struct {
    logic [N-1:0] vld;
    int           g;
  } vec_t;

  vec_t         tbl[14];
  int           rk;
  int           issues;
  logic [N-1:0] rdy_prev;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_vld = '0; req_x = '0;
    tick(); tick(); rst = 1'b0;

    // Single requester: x=144 from requester 1, latency 3.
    req_vld = 4'b0010; req_x[63:32] = 32'd144;
    #1 check("single_rdy", 32'(req_rdy), 32'b0010);
    for (int k = 1; k <= 4; k++) begin
      tick(); req_vld = '0;
      #1;
      if (k < 4) begin
        check("single_busy", 32'(busy), 1);
        check("single_rsp_idle", 32'(rsp_vld), 0);
      end else begin
        check("single_rsp_vld", 32'(rsp_vld), 32'b0010);
        check("single_rsp_y", 32'(rsp_y), 12);
        check("single_busy_end", 32'(busy), 0);
      end
    end

    // Grant table from ptr = 0; rows 0..2 are the fairness-after-idle sequence.
    tbl = '{'{4'b1000, 3}, '{4'b1001, 0}, '{4'b1000, 3}, '{4'b0110, 1},
            '{4'b0100, 2}, '{4'b0011, 0}, '{4'b0010, 1}, '{4'b1011, 3},
            '{4'b0000, -1}, '{4'b1111, 0}, '{4'b1110, 1}, '{4'b1100, 2},
            '{4'b1000, 3}, '{4'b0101, 0}};
    wait_idle();
    do_reset();
    for (int r = 0; r < 14; r++) begin
      req_vld = tbl[r].vld;
      for (int i = 0; i < N; i++) req_x[32*i +: 32] = 32'((r * 16 + i + 1) * (r * 16 + i + 1));
      #1;
      check($sformatf("tbl%0d_rdy", r), 32'(req_rdy), (tbl[r].g < 0) ? 0 : (32'd1 << tbl[r].g));
      check($sformatf("tbl%0d_x", r), isqrt_x,
            (tbl[r].g < 0) ? 0 : 32'((r * 16 + tbl[r].g + 1) * (r * 16 + tbl[r].g + 1)));
      tick();
    end

    // All requesters continuously valid with x_i = (i+2)^2.
    wait_idle();
    do_reset();
    for (int i = 0; i < N; i++) req_x[32*i +: 32] = 32'((i + 2) * (i + 2));
    rk = 0;
    for (int c = 0; c < 30; c++) begin
      req_vld = (c < 12) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 12) check("cont_grant", 32'(req_rdy), 32'd1 << (c % N));
      if (rsp_vld != 0) begin
        check("cont_rsp_vld", 32'(rsp_vld), 32'd1 << (rk % N));
        check("cont_rsp_y", 32'(rsp_y), 32'(rk % N + 2));
        rk++;
      end
      tick();
    end
    check("cont_rsp_count", 32'(rk), 12);

    // Full FIFO: latency 20, depth 16.
    wait_idle();
    set_lat(20);
    issues = 0;
    for (int c = 0; c < 25; c++) begin
      req_vld = 4'b1111;
      for (int i = 0; i < N; i++) req_x[32*i +: 32] = $urandom;
      #1;
      if (req_rdy != 0) issues++;
      if (c == 19) check("full_issue_count", 32'(issues), 16);
      if (c == 20) check("full_pop_no_grant", 32'(req_rdy), 0);
      if (c == 21) check("full_resume", 32'(isqrt_x_vld), 1);
      tick();
    end

    // Reset with 5 requests outstanding.
    wait_idle();
    for (int c = 0; c < 5; c++) begin
      req_vld = 4'b0001;
      req_x[31:0] = 32'(1000 * c + 7);
      tick();
    end
    req_vld = '0;
    #1 check("midrst_busy_before", 32'(busy), 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rsp_y", 32'(rsp_y), 0);
    check("midrst_err", 32'(err_orphan), 0);
    check("midrst_xvld", 32'(isqrt_x_vld), 0);
    for (int c = 0; c < 30; c++) begin
      tick();
      #1 check("midrst_no_rsp", 32'(rsp_vld), 0);
    end
    set_lat(3);

    // Orphan result with empty FIFO.
    wait_idle();
    force_orphan = 1'b1;
    tick(); force_orphan = 1'b0;
    #1;
    check("orphan_err", 32'(err_orphan), 32'(ORPHAN_EN));
    check("orphan_rsp", 32'(rsp_vld), 0);
    repeat (3) tick();
    #1;
    check("orphan_sticky", 32'(err_orphan), 32'(ORPHAN_EN));
    check("orphan_rsp_later", 32'(rsp_vld), 0);

    // Random traffic obeying the hold-until-ready handshake; the model checks every cycle.
    for (int ph = 0; ph < 3; ph++) begin
      wait_idle();
      set_lat((ph == 0) ? 1 : (ph == 1) ? 4 : 20);
      rdy_prev = '0;
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!req_vld[i] || rdy_prev[i]) begin
            req_vld[i] = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
              0:       req_x[32*i +: 32] = 32'hFFFF_FFFF;
              1:       req_x[32*i +: 32] = 32'd0;
              default: req_x[32*i +: 32] = $urandom;
            endcase
          end
        end
        #1 rdy_prev = req_rdy;
        tick();
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
